// File: rtl/video_pattern_gen_if.sv
// rtl/video_pattern_gen_if.sv - pixel stream bundle: pixel enable, sync/blank and 8-bit RGB
interface video_pattern_gen_if;
    logic       pix_ce;
    logic       hblank;
    logic       vblank;
    logic       hs;
    logic       vs;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    modport master (output pix_ce, hblank, vblank, hs, vs, red, green, blue);
    modport slave  (input  pix_ce, hblank, vblank, hs, vs, red, green, blue);
endinterface

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - video timing and test-pattern source (bars, column dither, checkerboard, solid)
module video_pattern_gen #(
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 28,
    parameter int H_BP     = 36,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 12,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 23
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [1:0]            pattern,
    input  logic [23:0]           solid_rgb,
    output logic [7:0]            frame_cnt,
    video_pattern_gen_if.master   vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [DW-1:0] DIV_LAST     = DW'(CE_DIV - 1);
    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST     = BW'(BAR_W - 1);

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [1:0]    pat_q;
    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;

    logic          ce;
    logic          h_wrap;
    logic          v_wrap;
    logic          frame_start;
    logic [1:0]    pat_use;
    logic [23:0]   bar_rgb;
    logic [23:0]   pix_rgb;

    assign ce          = enable && (div_cnt == DIV_LAST);
    // Gated by reset_n so the pixel enable is low during reset even when CE_DIV = 1.
    assign vid.pix_ce  = reset_n & ce;
    assign h_wrap      = (hcnt == H_LAST);
    assign v_wrap      = (vcnt == V_LAST);
    assign frame_start = (hcnt == '0) && (vcnt == '0);
    // The first pixel of a frame already uses the newly latched pattern.
    assign pat_use     = frame_start ? pattern : pat_q;

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pix_rgb = 24'h000000;
        case (pat_use)
            2'd0:    pix_rgb = bar_rgb;
            2'd1:    pix_rgb = hcnt[0] ? 24'h000000 : solid_rgb;
            2'd2:    pix_rgb = (hcnt[3] ^ vcnt[3]) ? 24'hFFFFFF : 24'h000000;
            default: pix_rgb = solid_rgb;
        endcase
        if ((hcnt >= H_ACT_END) || (vcnt >= V_ACT_END)) begin
            pix_rgb = 24'h000000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // Counters and registered decode; outputs show position N after the pix_ce at N.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt       <= '0;
            vcnt       <= '0;
            frame_cnt  <= '0;
            pat_q      <= '0;
            bar_px     <= '0;
            bar_idx    <= '0;
            vid.hblank <= 1'b1;
            vid.vblank <= 1'b1;
            vid.hs     <= 1'b0;
            vid.vs     <= 1'b0;
            vid.red    <= '0;
            vid.green  <= '0;
            vid.blue   <= '0;
        end else if (ce) begin
            hcnt <= h_wrap ? '0 : hcnt + 1'b1;
            if (h_wrap) begin
                vcnt <= v_wrap ? '0 : vcnt + 1'b1;
                if (v_wrap) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (frame_start) begin
                pat_q <= pattern;
            end
            // Bar sub-counter tracks hcnt so the bar index needs no divider.
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_px  <= bar_px + 1'b1;
            end
            vid.hblank <= (hcnt >= H_ACT_END);
            vid.vblank <= (vcnt >= V_ACT_END);
            vid.hs     <= (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
            vid.vs     <= (vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END);
            vid.red    <= pix_rgb[23:16];
            vid.green  <= pix_rgb[15:8];
            vid.blue   <= pix_rgb[7:0];
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - directed bench for video_pattern_gen (default timing and a small CE_DIV=1 instance)
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, en_a, en_b;
    logic [1:0]  pat_a, pat_b;
    logic [23:0] solid;
    logic [7:0]  fc_a, fc_b;
    int          checks = 0;
    int          errors = 0;
    int          ka;

    always #5 clk = ~clk;

    video_pattern_gen_if va();
    video_pattern_gen_if vb();

    video_pattern_gen dut_a (
        .clk(clk), .reset_n(rst_a), .enable(en_a), .pattern(pat_a),
        .solid_rgb(solid), .frame_cnt(fc_a), .vid(va)
    );

    video_pattern_gen #(
        .CE_DIV(1), .H_ACTIVE(32), .H_FP(4), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .clk(clk), .reset_n(rst_b), .enable(en_b), .pattern(pat_b),
        .solid_rgb(solid), .frame_cnt(fc_b), .vid(vb)
    );

    function automatic logic [27:0] get_out(input int which);
        if (which == 0)
            return {va.hblank, va.vblank, va.hs, va.vs, va.red, va.green, va.blue};
        return {vb.hblank, vb.vblank, vb.hs, vb.vs, vb.red, vb.green, vb.blue};
    endfunction

    function automatic logic [23:0] bar_color(input int i);
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected {hblank, vblank, hs, vs, rgb} for counter position (h, v).
    function automatic logic [27:0] exp_out(input int which, input int h, input int v, input int pat);
        int ha, hf, hsw, vact, vf, vsw;
        logic [23:0] rgb;
        if (which == 0) begin
            ha = 320; hf = 16; hsw = 28; vact = 224; vf = 12; vsw = 3;
        end else begin
            ha = 32;  hf = 4;  hsw = 3;  vact = 20;  vf = 2;  vsw = 2;
        end
        rgb = 24'h000000;
        if (h < ha && v < vact) begin
            case (pat)
                0:       rgb = bar_color(h / (ha / 8));
                1:       rgb = (h % 2 == 0) ? solid : 24'h000000;
                2:       rgb = (((h / 8) % 2) != ((v / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
                default: rgb = solid;
            endcase
        end
        return {h >= ha, v >= vact, (h >= ha + hf) && (h < ha + hf + hsw),
                (v >= vact + vf) && (v < vact + vf + vsw), rgb};
    endfunction

    // Advance to just after the next pix_ce edge; cyc is clk cycles waited.
    task automatic step(input int which, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (((which == 0) ? va.pix_ce : vb.pix_ce) === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL step_timeout dut=%0d: no pix_ce within 16 clk", which);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
        pat_a = 2'd0; pat_b = 2'd0; solid = 24'h123456;
        repeat (3) @(negedge clk);
        checks++; if (get_out(0) !== 28'hC000000) begin errors++; $display("FAIL reset_out_a: got %h want %h", get_out(0), 28'hC000000); end
        checks++; if (get_out(1) !== 28'hC000000) begin errors++; $display("FAIL reset_out_b: got %h want %h", get_out(1), 28'hC000000); end
        checks++; if (va.pix_ce !== 1'b0) begin errors++; $display("FAIL reset_pix_ce_a: got %b want 0", va.pix_ce); end
        checks++; if (vb.pix_ce !== 1'b0) begin errors++; $display("FAIL reset_pix_ce_b: got %b want 0", vb.pix_ce); end
        checks++; if (fc_a !== 8'd0) begin errors++; $display("FAIL reset_frame_a: got %0d want 0", fc_a); end
        checks++; if (fc_b !== 8'd0) begin errors++; $display("FAIL reset_frame_b: got %0d want 0", fc_b); end
    endtask

    task automatic test_timing_bars();
        int cyc;
        logic [27:0] e;
        @(posedge clk); #1;
        rst_a = 1'b1; en_a = 1'b1;
        for (int k = 0; k < 410; k++) begin
            step(0, cyc);
            if (k >= 2 && k < 6) begin
                checks++;
                if (cyc != 4) begin errors++; $display("FAIL pix_ce_period: got %0d clk want 4", cyc); end
            end
            e = exp_out(0, k % 400, k / 400, 0);
            checks++;
            if (get_out(0) !== e) begin errors++; $display("FAIL bars_px%0d: got %h want %h", k, get_out(0), e); end
        end
        ka = 410;
    endtask

    task automatic test_enable_freeze();
        int cyc;
        logic [27:0] snap, e;
        for (int k = 0; k < 3; k++) begin
            step(0, cyc);
            e = exp_out(0, ka % 400, ka / 400, 0);
            checks++;
            if (get_out(0) !== e) begin errors++; $display("FAIL pre_freeze_px%0d: got %h want %h", ka, get_out(0), e); end
            ka++;
        end
        snap = get_out(0);
        en_a = 1'b0;
        for (int c = 0; c < 37; c++) begin
            @(negedge clk);
            checks++;
            if (va.pix_ce !== 1'b0 || get_out(0) !== snap) begin
                errors++;
                $display("FAIL freeze_cyc%0d: pix_ce %b out %h want 0 %h", c, va.pix_ce, get_out(0), snap);
            end
        end
        en_a = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(0, cyc);
            e = exp_out(0, ka % 400, ka / 400, 0);
            checks++;
            if (get_out(0) !== e) begin errors++; $display("FAIL resume_px%0d: got %h want %h", ka, get_out(0), e); end
            ka++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        checks++; if (get_out(0) !== 28'hC000000) begin errors++; $display("FAIL async_reset_out: got %h want %h", get_out(0), 28'hC000000); end
        checks++; if (va.pix_ce !== 1'b0) begin errors++; $display("FAIL async_reset_pix_ce: got %b want 0", va.pix_ce); end
        checks++; if (fc_a !== 8'd0) begin errors++; $display("FAIL async_reset_frame: got %0d want 0", fc_a); end
        pat_a = 2'd1;
        solid = 24'h80C0FF;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;
    endtask

    task automatic test_dither();
        int cyc;
        logic [27:0] e;
        for (int k = 0; k < 330; k++) begin
            step(0, cyc);
            e = exp_out(0, k, 0, 1);
            checks++;
            if (get_out(0) !== e) begin errors++; $display("FAIL dither_px%0d: got %h want %h", k, get_out(0), e); end
        end
    endtask

    task automatic test_ce_div1_frames();
        int cyc;
        logic [27:0] e;
        pat_b = 2'd0;
        @(posedge clk); #1;
        rst_b = 1'b1; en_b = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < 26; v++) begin
                for (int h = 0; h < 44; h++) begin
                    if (f == 0 && v == 10 && h == 0) pat_b = 2'd2;
                    step(1, cyc);
                    if (f == 0 && v == 0 && h < 8) begin
                        checks++;
                        if (cyc != 1) begin errors++; $display("FAIL ce1_period: got %0d clk want 1", cyc); end
                    end
                    e = exp_out(1, h, v, (f == 0) ? 0 : 2);
                    checks++;
                    if (get_out(1) !== e) begin errors++; $display("FAIL small_f%0d_v%0d_h%0d: got %h want %h", f, v, h, get_out(1), e); end
                end
            end
            checks++;
            if (fc_b !== 8'(f + 1)) begin errors++; $display("FAIL frame_cnt_f%0d: got %0d want %0d", f, fc_b, f + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_timing_bars();
        test_enable_freeze();
        test_async_reset();
        test_dither();
        test_ce_div1_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
